// File: rtl/key_device.sv
// key_device: memory-mapped pushbutton controller.
//   KDATA (ADDRKDATA): accepted key state, 1 = pressed, in bits [3:0].
//   KCTRL (ADDRKCTRL): bit0 READY, bit2 OVERRUN, bit8 IE.
// Build option: define KEY_DEBOUNCE_EN to add a per-key stability counter
// of DEBOUNCE_CYCLES clocks; otherwise the synchronized keys are accepted
// every cycle.
module key_device #(
    parameter int              DBITS           = 32,
    parameter logic [DBITS-1:0] ADDRKDATA      = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL      = 32'hFFFFF084,
    parameter int              DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [3:0]       KEY,
    input  logic [DBITS-1:0] memaddr_M,
    input  logic             rdmem_M,
    input  logic             wrmem_M,
    input  logic [DBITS-1:0] wmemval_M,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    output logic             irq
);

    logic [3:0] sync_meta;
    logic [3:0] sync_key;
    logic [3:0] kstate;
    logic [3:0] kstate_next;
    logic       change_evt;
    logic       sel_data;
    logic       sel_ctrl;
    logic       rd_kdata;
    logic       wr_kctrl;
    logic       ready;
    logic       overrun;
    logic       ie;
    logic       unused_wdata;

    assign sel_data   = (memaddr_M == ADDRKDATA);
    assign sel_ctrl   = (memaddr_M == ADDRKCTRL);
    assign sel        = sel_data | sel_ctrl;
    assign rd_kdata   = sel_data & rdmem_M;
    assign wr_kctrl   = sel_ctrl & wrmem_M;
    assign change_evt = (kstate_next != kstate);

    // Only wmemval_M[2] and [8] carry meaning; the rest is deliberately dropped.
    assign unused_wdata = ^wmemval_M;

    // Two-flop synchronizer. The inversion happens at the input so that the
    // cleared (reset) value means "released" and a release after reset is not
    // mistaken for a press.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_meta <= '0;
            sync_key  <= '0;
        end else begin
            sync_meta <= ~KEY;
            sync_key  <= sync_meta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt [4];
    logic [3:0]    db_done;

    // A key bit is accepted once it has disagreed with KSTATE for the full window.
    always_comb begin
        db_done     = '0;
        kstate_next = kstate;
        for (int i = 0; i < 4; i++) begin
            db_done[i] = (sync_key[i] != kstate[i]) && (db_cnt[i] == CNT_LAST);
            if (db_done[i]) begin
                kstate_next[i] = sync_key[i];
            end
        end
    end

    // Per-key stability counters; they restart on agreement or acceptance, so never wrap.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ((sync_key[i] == kstate[i]) || db_done[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    assign kstate_next = sync_key;
`endif

    // Accepted key state.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            kstate <= '0;
        end else begin
            kstate <= kstate_next;
        end
    end

    // Status flags: a change event beats a KDATA read for READY, and a new
    // overrun beats a clearing KCTRL write.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (change_evt) begin
                ready <= 1'b1;
            end else if (rd_kdata) begin
                ready <= 1'b0;
            end

            if (change_evt && ready && !rd_kdata) begin
                overrun <= 1'b1;
            end else if (wr_kctrl && !wmemval_M[2]) begin
                overrun <= 1'b0;
            end

            if (wr_kctrl) begin
                ie <= wmemval_M[8];
            end
        end
    end

    // Zero-latency read mux.
    always_comb begin
        rdata = '0;
        if (sel_data) begin
            rdata[3:0] = kstate;
        end else if (sel_ctrl) begin
            rdata[0] = ready;
            rdata[2] = overrun;
            rdata[8] = ie;
        end
    end

    assign irq = ie & ready;

endmodule

// File: doc/key_device.md
KEY_DEVICE -- requirements
Module: key_device

Interface
REQ-001 Parameter: DBITS, default 32, data-bus width.
REQ-002 Parameter: ADDRKDATA, default 32'hFFFFF080, key data register address.
REQ-003 Parameter: ADDRKCTRL, default 32'hFFFFF084, key control/status register address.
REQ-004 Parameter: DEBOUNCE_CYCLES, default 500000, stability window in clk cycles (10 ms at 50 MHz).
REQ-005 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port: RESET_N  input  1  reset, asynchronous and active-low.
REQ-007 Port: KEY  input  4  raw board pushbuttons, active-low (0 = pressed), asynchronous to clk.
REQ-008 Port: memaddr_M  input  DBITS  memory-stage byte address.
REQ-009 Port: rdmem_M  input  1  memory-stage load strobe, one cycle per load.
REQ-010 Port: wrmem_M  input  1  memory-stage store strobe, one cycle per store.
REQ-011 Port: wmemval_M  input  DBITS  store data.
REQ-012 Port: sel  output  1  high when memaddr_M equals ADDRKDATA or ADDRKCTRL.
REQ-013 Port: rdata  output  DBITS  read data for the selected register; 0 when sel is low.
REQ-014 Port: irq  output  1  interrupt request.

Function
REQ-015 Each KEY bit SHALL pass through a 2-flop synchronizer, then be inverted so that 1 = pressed.
REQ-016 The accepted key state KSTATE[3:0] SHALL be updated per the Configuration section.
REQ-017 A KSTATE change event SHALL be any cycle in which KSTATE's next value differs from its current value.
REQ-018 rdata SHALL be combinational from memaddr_M and the registers, with zero-cycle latency.
REQ-019 KDATA read SHALL return {DBITS-4 zeros, KSTATE}.
REQ-020 KCTRL read SHALL return bit0 = READY, bit2 = OVERRUN, bit8 = IE, and 0 in all other bits.
REQ-021 READY SHALL be set on the edge following a change event.
REQ-022 READY SHALL be cleared on the edge where rdmem_M is high and memaddr_M equals ADDRKDATA.
REQ-023 A change event SHALL set OVERRUN if READY is already 1 and READY is not being cleared in the same cycle.
REQ-024 A KCTRL write with wmemval_M[2]=0 SHALL clear OVERRUN; writing 1 to bit2 SHALL have no effect.
REQ-025 Writes to READY SHALL be ignored; a KCTRL write SHALL load IE from wmemval_M[8].
REQ-026 KDATA writes SHALL be ignored.
REQ-027 A change event coincident with a KDATA read SHALL leave READY=1 and SHALL NOT set OVERRUN.
REQ-028 An OVERRUN set coincident with an OVERRUN clear write SHALL leave OVERRUN=1 (set wins).
REQ-029 irq SHALL equal IE AND READY, driven from registered state only.
REQ-030 When sel is low, the rdmem_M and wrmem_M strobes SHALL cause no state change.

Reset
REQ-031 Assertion of RESET_N low SHALL immediately clear the synchronizers, debounce counters, KSTATE, READY, OVERRUN and IE.
REQ-032 While in reset, rdata SHALL be 0 when sel is low and irq SHALL be 0.
REQ-033 The first change event SHALL be detectable no earlier than 2 cycles after RESET_N deasserts.
REQ-034 A press held through reset SHALL produce a change event once it has been synchronized (and debounced, if enabled) after reset.

Configuration
REQ-035 The macro KEY_DEBOUNCE_EN SHALL control debouncing.
REQ-036 With KEY_DEBOUNCE_EN defined, each bit SHALL have its own counter, counting up while the synchronized value differs from KSTATE and zeroed when it matches.
REQ-037 With KEY_DEBOUNCE_EN defined, KSTATE's bit SHALL take the synchronized value when its counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL then zero.
REQ-038 With KEY_DEBOUNCE_EN defined, the counter width SHALL be $clog2(DEBOUNCE_CYCLES) and the counter SHALL never wrap.
REQ-039 Without KEY_DEBOUNCE_EN, KSTATE SHALL be loaded from the synchronized value every cycle, and no counters SHALL exist.

Verification
REQ-040 No debounce: KEY goes from 4'hF to 4'hE at cycle 10 -> KSTATE = 4'h1 and READY = 1 by cycle 13; a KCTRL read returns 32'h1.
REQ-041 Debounce with DEBOUNCE_CYCLES=4: KEY[0] toggles every 2 cycles for 20 cycles, then is held low -> no event during the toggling; READY rises 4 cycles after synchronized stability.
REQ-042 Two presses with no intervening KDATA read -> KCTRL = 32'h5; a KCTRL write of 32'h0 gives 32'h1; a KDATA read gives READY = 0.
REQ-043 KDATA read in the same cycle as a change event -> READY stays 1 and OVERRUN stays 0.
REQ-044 KCTRL write of 32'h100, then a press -> irq rises in the READY-set cycle and falls the cycle after a KDATA read.
REQ-045 RESET_N pulled low mid-debounce, for 3 cycles asynchronous to clk -> all state is 0 at once and no spurious event follows release with KEY = 4'hF.
